// File: rtl/enemy_patrol.sv
// enemy_patrol: one enemy sprite that patrols or chases the player, dies when an
// explosion cross covers it, respawns after a number of movement ticks, and
// latches a sticky flag once it touches the player.
module enemy_patrol #(
    parameter int W             = 16,
    parameter int TICK_LIMIT    = 1400000,
    parameter int CNT_W         = 21,
    parameter int MIN_X         = 143,
    parameter int MAX_X         = 784,
    parameter int MIN_Y         = 34,
    parameter int MAX_Y         = 516,
    parameter int MODE          = 0,
    parameter int E_ARM         = 48,
    parameter int RESPAWN_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enemy_start,
    input  logic [9:0] set_x,
    input  logic [9:0] set_y,
    input  logic [3:0] enemy_blocked,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    input  logic [9:0] e_x,
    input  logic [9:0] e_y,
    input  logic       explosion_SCEN,
    input  logic [9:0] v_x,
    input  logic [9:0] v_y,
    output logic [9:0] enemy_x,
    output logic [9:0] enemy_y,
    output logic       enemy_on,
    output logic       enemy_alive,
    output logic       death_signal
);
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DEAD} state_t;
    // Encoding chosen so that +1 is a clockwise turn (L->U->R->D->L).
    typedef enum logic [1:0] {D_L = 2'd0, D_U = 2'd1, D_R = 2'd2, D_D = 2'd3} dir_t;

    localparam int RW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [RW-1:0]    RESP_LAST = RW'(RESPAWN_TICKS - 1);
    localparam logic [CNT_W-1:0] TICK_VAL  = CNT_W'(TICK_LIMIT);
    localparam logic [9:0]  X_LO  = 10'(MIN_X);
    localparam logic [9:0]  X_HI  = 10'(MAX_X - W);
    localparam logic [9:0]  Y_LO  = 10'(MIN_Y);
    localparam logic [9:0]  Y_HI  = 10'(MAX_Y - W);
    localparam logic [11:0] W12   = 12'(W);
    localparam logic [11:0] ARM12 = 12'(E_ARM);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    resp_q, resp_d;
    logic             death_q, death_d, alive_q, alive_d;

    // Half-open interval overlap; touching edges do not count.
    function automatic logic ov(input logic [11:0] a0, a1, b0, b1);
        return (a0 < b1) && (b0 < a1);
    endfunction

    // Geometry is done in 12 bits so bar ends past 1023 never wrap.
    logic [11:0] ax, ay, ex, ey, hx_lo, vy_lo;
    logic        kill_hit, bomb_hit;
    assign ax    = {2'b00, x_q};
    assign ay    = {2'b00, y_q};
    assign ex    = {2'b00, e_x};
    assign ey    = {2'b00, e_y};
    assign hx_lo = (ex >= ARM12) ? ex - ARM12 : 12'd0;
    assign vy_lo = (ey >= ARM12) ? ey - ARM12 : 12'd0;
    assign kill_hit =
        (ov(ax, ax + W12, hx_lo, ex + W12 + ARM12) && ov(ay, ay + W12, ey, ey + W12)) ||
        (ov(ax, ax + W12, ex, ex + W12) && ov(ay, ay + W12, vy_lo, ey + W12 + ARM12));
    assign bomb_hit = ov(ax, ax + W12, {2'b00, b_x}, {2'b00, b_x} + W12) &&
                      ov(ay, ay + W12, {2'b00, b_y}, {2'b00, b_y} + W12);

    assign enemy_on = alive_q &&
                      ({2'b00, v_x} >= ax) && ({2'b00, v_x} < ax + W12) &&
                      ({2'b00, v_y} >= ay) && ({2'b00, v_y} < ay + W12);
    assign enemy_x      = x_q;
    assign enemy_y      = y_q;
    assign enemy_alive  = alive_q;
    assign death_signal = death_q;

    logic               tick;
    logic [3:0]         legal;
    logic signed [10:0] dx, dy, adx, ady;
    logic               mv_en, rot;
    dir_t               mv_dir, pd, sd;
    logic               pnz, snz;

    assign tick = (cnt_q == TICK_VAL);
    assign dx   = $signed({1'b0, b_x}) - $signed({1'b0, x_q});
    assign dy   = $signed({1'b0, b_y}) - $signed({1'b0, y_q});
    assign adx  = dx[10] ? -dx : dx;
    assign ady  = dy[10] ? -dy : dy;

    // Per-direction step legality and the movement decision for this tick.
    always_comb begin
        legal      = '0;
        legal[D_L] = !enemy_blocked[0] && (x_q > X_LO);
        legal[D_U] = !enemy_blocked[2] && (y_q > Y_LO);
        legal[D_R] = !enemy_blocked[1] && (x_q < X_HI);
        legal[D_D] = !enemy_blocked[3] && (y_q < Y_HI);
        mv_en  = 1'b0;
        rot    = 1'b0;
        mv_dir = dir_q;
        // Primary axis is the longer distance; ties favour X.
        if (adx >= ady) begin
            pd = dx[10] ? D_L : D_R;  pnz = (dx != 0);
            sd = dy[10] ? D_U : D_D;  snz = (dy != 0);
        end else begin
            pd = dy[10] ? D_U : D_D;  pnz = (dy != 0);
            sd = dx[10] ? D_L : D_R;  snz = (dx != 0);
        end
        if (MODE == 0) begin
            if (legal[dir_q]) mv_en = 1'b1;
            else              rot   = 1'b1;
        end else begin
            if (pnz && legal[pd]) begin
                mv_en = 1'b1; mv_dir = pd;
            end else if (snz && legal[sd]) begin
                mv_en = 1'b1; mv_dir = sd;
            end
        end
    end

    // Next-state logic: start, tick-driven movement, kill, respawn.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        death_d = death_q;
        case (state_q)
            S_IDLE: begin
                if (explosion_SCEN && kill_hit) begin
                    state_d = S_DEAD;
                end else if (enemy_start) begin
                    state_d = S_MOVE;
                    cnt_d   = '0;
                    dir_d   = D_L;
                end
            end
            S_MOVE: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (bomb_hit) death_d = 1'b1;
                // Kill wins over a step on the same clock; position freezes.
                if (explosion_SCEN && kill_hit) begin
                    state_d = S_DEAD;
                end else if (tick) begin
                    if (mv_en) begin
                        dir_d = mv_dir;
                        case (mv_dir)
                            D_L:     x_d = x_q - 10'd1;
                            D_R:     x_d = x_q + 10'd1;
                            D_U:     y_d = y_q - 10'd1;
                            default: y_d = y_q + 10'd1;
                        endcase
                    end else if (rot) begin
                        dir_d = dir_t'(dir_q + 2'd1);
                    end
                end
            end
            S_DEAD: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (tick && (RESPAWN_TICKS != 0)) begin
                    if (resp_q == RESP_LAST) begin
                        state_d = S_MOVE;
                        x_d     = set_x;
                        y_d     = set_y;
                        dir_d   = D_L;
                        cnt_d   = '0;
                        resp_d  = '0;
                    end else begin
                        resp_d = resp_q + RW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        alive_d = (state_d != S_DEAD);
    end

    // State registers; reset reloads the spawn position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dir_q   <= D_L;
            x_q     <= set_x;
            y_q     <= set_y;
            cnt_q   <= '0;
            resp_q  <= '0;
            death_q <= 1'b0;
            alive_q <= 1'b1;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            death_q <= death_d;
            alive_q <= alive_d;
        end
    end
endmodule
